// File: rtl/bus_interconnect_ws_if.sv
// rtl/bus_interconnect_ws_if.sv - CPU-side and slave-side bus signals of the wait-state interconnect
interface bus_interconnect_ws_if #(
    parameter int NUM_SLAVES = 8
);
    logic [31:0]              mem_addr;
    logic                     mem_rstrb;
    logic [3:0]               mem_wmask;
    logic [31:0]              mem_rdata;
    logic                     mem_rbusy;
    logic                     mem_wbusy;
    logic [NUM_SLAVES-1:0]    cs;
    logic                     s_rd;
    logic                     s_wr;
    logic [32*NUM_SLAVES-1:0] s_rdata;
    logic [NUM_SLAVES-1:0]    s_ready;
    logic                     err_clr;
    logic                     bus_err;
    logic [31:0]              err_addr;

    // Interconnect side.
    modport slave (
        input  mem_addr, mem_rstrb, mem_wmask, s_rdata, s_ready, err_clr,
        output mem_rdata, mem_rbusy, mem_wbusy, cs, s_rd, s_wr, bus_err, err_addr
    );

    // CPU/peripheral side.
    modport master (
        output mem_addr, mem_rstrb, mem_wmask, s_rdata, s_ready, err_clr,
        input  mem_rdata, mem_rbusy, mem_wbusy, cs, s_rd, s_wr, bus_err, err_addr
    );
endinterface

// File: rtl/bus_interconnect_ws.sv
// rtl/bus_interconnect_ws.sv - address decoder, read mux and wait-state handshake with timeout watchdog
module bus_interconnect_ws #(
    parameter int          NUM_SLAVES  = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0040_0000,
    parameter int          REGION_BITS = 16,
    parameter int          TIMEOUT     = 15,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic          clk,
    input  logic          resetn,
    bus_interconnect_ws_if.slave bus
);
    localparam int          IDX_W    = $clog2(NUM_SLAVES);
    localparam logic [31:0] WIN_SIZE = 32'(NUM_SLAVES - 1) << REGION_BITS;
    localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              wr_q, wr_d;
    logic [31:0]       addr_q, addr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rbusy_q, rbusy_d;
    logic              wbusy_q, wbusy_d;
    logic              bus_err_q, bus_err_d;
    logic [31:0]       err_addr_q, err_addr_d;

    logic [31:0]           offset;
    logic                  in_win;
    logic [IDX_W-1:0]      dec_idx;
    logic [IDX_W-1:0]      cur_idx;
    logic                  req;
    logic                  is_wr;
    logic                  ready_sel;
    logic [31:0]           rdata_sel;
    logic [NUM_SLAVES-1:0] cs_c;
    logic                  s_rd_c;
    logic                  s_wr_c;

    // Addresses outside the peripheral window fall through to the last slave (RAM).
    always_comb begin
        offset  = bus.mem_addr - BASE_ADDR;
        in_win  = (bus.mem_addr >= BASE_ADDR) && (offset < WIN_SIZE);
        dec_idx = in_win ? IDX_W'(offset >> REGION_BITS) : IDX_W'(NUM_SLAVES - 1);
        is_wr   = |bus.mem_wmask;
        req     = bus.mem_rstrb | is_wr;
        cur_idx = (state_q == S_IDLE) ? dec_idx : idx_q;
        ready_sel = bus.s_ready[cur_idx];
        rdata_sel = bus.s_rdata[{cur_idx, 5'd0} +: 32];
    end

    always_comb begin
        cs_c   = '0;
        s_rd_c = 1'b0;
        s_wr_c = 1'b0;
        if (state_q == S_IDLE) begin
            if (req) begin
                cs_c   = NUM_SLAVES'(1) << dec_idx;
                s_wr_c = is_wr;
                s_rd_c = ~is_wr;
            end
        end else begin
            cs_c = NUM_SLAVES'(1) << idx_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        rbusy_d    = 1'b0;
        wbusy_d    = 1'b0;
        bus_err_d  = bus_err_q & ~bus.err_clr;
        err_addr_d = err_addr_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d  = dec_idx;
                    wr_d   = is_wr;
                    addr_d = bus.mem_addr;
                    if (ready_sel) begin
                        if (!is_wr) rdata_d = rdata_sel;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                        rbusy_d = ~is_wr;
                        wbusy_d = is_wr;
                    end
                end
            end
            S_WAIT: begin
                // Ready in the final cycle still counts as a normal completion.
                if (ready_sel) begin
                    if (!wr_q) rdata_d = rdata_sel;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    if (!wr_q) rdata_d = ERR_DATA;
                    bus_err_d  = 1'b1;
                    err_addr_d = addr_q;
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    rbusy_d = ~wr_q;
                    wbusy_d = wr_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            rbusy_q    <= 1'b0;
            wbusy_q    <= 1'b0;
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            rbusy_q    <= rbusy_d;
            wbusy_q    <= wbusy_d;
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign bus.cs        = cs_c;
    assign bus.s_rd      = s_rd_c;
    assign bus.s_wr      = s_wr_c;
    assign bus.mem_rdata = rdata_q;
    assign bus.mem_rbusy = rbusy_q;
    assign bus.mem_wbusy = wbusy_q;
    assign bus.bus_err   = bus_err_q;
    assign bus.err_addr  = err_addr_q;
endmodule

// File: tb/tb_bus_interconnect_ws.sv
// tb/tb_bus_interconnect_ws.sv - directed vector bench for bus_interconnect_ws
module tb_bus_interconnect_ws;
    logic clk;
    logic resetn;
    int   n_tests;
    int   n_fail;

    bus_interconnect_ws_if #(.NUM_SLAVES(8)) bus ();

    bus_interconnect_ws dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        rstrb;
        logic [3:0]  wmask;
        logic [7:0]  exp_cs;
        logic        exp_rd;
        logic        exp_wr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        resetn  = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_rstrb = 1'b0;
        bus.mem_wmask = '0;
        bus.s_ready   = '0;
        bus.err_clr   = 1'b0;
        for (int i = 0; i < 8; i++) bus.s_rdata[32*i +: 32] = 32'hC0DE_0000 + 32'(i);
        bus.s_rdata[32*7 +: 32] = 32'h1234_5678;

        vecs[0] = '{32'h0000_1000, 1'b1, 4'h0, 8'h80, 1'b1, 1'b0, 32'h1234_5678};
        vecs[1] = '{32'h0040_0004, 1'b1, 4'h0, 8'h01, 1'b1, 1'b0, 32'hC0DE_0000};
        vecs[2] = '{32'h0042_0000, 1'b1, 4'h0, 8'h04, 1'b1, 1'b0, 32'hC0DE_0002};
        vecs[3] = '{32'h0046_FFFC, 1'b1, 4'h0, 8'h40, 1'b1, 1'b0, 32'hC0DE_0006};
        vecs[4] = '{32'h0047_0000, 1'b1, 4'h0, 8'h80, 1'b1, 1'b0, 32'h1234_5678};
        vecs[5] = '{32'h0043_0008, 1'b1, 4'h0, 8'h08, 1'b1, 1'b0, 32'hC0DE_0003};
        vecs[6] = '{32'h0045_0000, 1'b1, 4'hF, 8'h20, 1'b0, 1'b1, 32'hC0DE_0003};
        vecs[7] = '{32'h003F_FFFC, 1'b1, 4'h0, 8'h80, 1'b1, 1'b0, 32'h1234_5678};
        vecs[8] = '{32'h0041_0000, 1'b1, 4'h0, 8'h02, 1'b1, 1'b0, 32'hC0DE_0001};

        @(negedge clk);
        @(negedge clk);
        chk("reset_rdata", bus.mem_rdata, 32'h0);
        chk("reset_rbusy", 32'(bus.mem_rbusy), 32'h0);
        chk("reset_wbusy", 32'(bus.mem_wbusy), 32'h0);
        chk("reset_cs", 32'(bus.cs), 32'h0);
        chk("reset_bus_err", 32'(bus.bus_err), 32'h0);
        chk("reset_err_addr", bus.err_addr, 32'h0);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.mem_addr  = vecs[i].addr;
            bus.mem_rstrb = vecs[i].rstrb;
            bus.mem_wmask = vecs[i].wmask;
            bus.s_ready   = 8'hFF;
            #1;
            chk($sformatf("vec%0d_cs", i), 32'(bus.cs), 32'(vecs[i].exp_cs));
            chk($sformatf("vec%0d_s_rd", i), 32'(bus.s_rd), 32'(vecs[i].exp_rd));
            chk($sformatf("vec%0d_s_wr", i), 32'(bus.s_wr), 32'(vecs[i].exp_wr));
            @(negedge clk);
            bus.mem_rstrb = 1'b0;
            bus.mem_wmask = '0;
            #1;
            chk($sformatf("vec%0d_rdata", i), bus.mem_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_rbusy", i), 32'(bus.mem_rbusy), 32'h0);
            chk($sformatf("vec%0d_wbusy", i), 32'(bus.mem_wbusy), 32'h0);
        end

        // Read with three wait states; a stray ready from slave 5 must be ignored.
        @(negedge clk);
        bus.mem_addr = 32'h0042_0000; bus.mem_rstrb = 1'b1; bus.s_ready = 8'h00;
        #1;
        chk("ws_cs_T", 32'(bus.cs), 32'h04);
        chk("ws_s_rd_T", 32'(bus.s_rd), 32'h1);
        @(negedge clk);
        bus.mem_rstrb = 1'b0; bus.s_ready = 8'h20;
        #1;
        chk("ws_rbusy_T1", 32'(bus.mem_rbusy), 32'h1);
        chk("ws_s_rd_T1", 32'(bus.s_rd), 32'h0);
        chk("ws_cs_T1", 32'(bus.cs), 32'h04);
        @(negedge clk);
        bus.s_ready = 8'h00;
        #1;
        chk("ws_rbusy_T2", 32'(bus.mem_rbusy), 32'h1);
        @(negedge clk);
        bus.s_ready = 8'h04;
        #1;
        chk("ws_rbusy_T3", 32'(bus.mem_rbusy), 32'h1);
        @(negedge clk);
        bus.s_ready = 8'h00;
        #1;
        chk("ws_rbusy_T4", 32'(bus.mem_rbusy), 32'h0);
        chk("ws_rdata_T4", bus.mem_rdata, 32'hC0DE_0002);

        // Write with two wait states leaves mem_rdata alone.
        @(negedge clk);
        bus.mem_addr = 32'h0040_0000; bus.mem_wmask = 4'b0011;
        #1;
        chk("wr_s_wr_T", 32'(bus.s_wr), 32'h1);
        chk("wr_s_rd_T", 32'(bus.s_rd), 32'h0);
        chk("wr_cs_T", 32'(bus.cs), 32'h01);
        @(negedge clk);
        bus.mem_wmask = '0;
        #1;
        chk("wr_wbusy_T1", 32'(bus.mem_wbusy), 32'h1);
        chk("wr_rbusy_T1", 32'(bus.mem_rbusy), 32'h0);
        chk("wr_s_wr_T1", 32'(bus.s_wr), 32'h0);
        @(negedge clk);
        bus.s_ready = 8'h01;
        #1;
        chk("wr_wbusy_T2", 32'(bus.mem_wbusy), 32'h1);
        @(negedge clk);
        bus.s_ready = 8'h00;
        #1;
        chk("wr_wbusy_T3", 32'(bus.mem_wbusy), 32'h0);
        chk("wr_rdata_T3", bus.mem_rdata, 32'hC0DE_0002);

        // Timeout on slave 1.
        @(negedge clk);
        bus.mem_addr = 32'h0041_0010; bus.mem_rstrb = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            bus.mem_rstrb = 1'b0;
            #1;
            chk($sformatf("to_rbusy_T%0d", k), 32'(bus.mem_rbusy), 32'h1);
        end
        @(negedge clk);
        #1;
        chk("to_rbusy_after", 32'(bus.mem_rbusy), 32'h0);
        chk("to_rdata", bus.mem_rdata, 32'hDEAD_BEEF);
        chk("to_bus_err", 32'(bus.bus_err), 32'h1);
        chk("to_err_addr", bus.err_addr, 32'h0041_0010);
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        #1;
        chk("clr_bus_err", 32'(bus.bus_err), 32'h0);
        chk("clr_err_addr_kept", bus.err_addr, 32'h0041_0010);

        // New timeout coinciding with err_clr: the set wins.
        @(negedge clk);
        bus.mem_addr = 32'h0043_0020; bus.mem_rstrb = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            bus.mem_rstrb = 1'b0;
            if (k == 15) bus.err_clr = 1'b1;
        end
        @(negedge clk);
        bus.err_clr = 1'b0;
        #1;
        chk("set_wins_bus_err", 32'(bus.bus_err), 32'h1);
        chk("set_wins_err_addr", bus.err_addr, 32'h0043_0020);
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        #1;
        chk("clr2_bus_err", 32'(bus.bus_err), 32'h0);

        // Ready in the last allowed wait cycle beats the timeout.
        @(negedge clk);
        bus.mem_addr = 32'h0041_0000; bus.mem_rstrb = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            bus.mem_rstrb = 1'b0;
            if (k == 15) bus.s_ready = 8'h02;
        end
        @(negedge clk);
        bus.s_ready = 8'h00;
        #1;
        chk("tie_bus_err", 32'(bus.bus_err), 32'h0);
        chk("tie_rdata", bus.mem_rdata, 32'hC0DE_0001);
        chk("tie_rbusy", 32'(bus.mem_rbusy), 32'h0);

        // Asynchronous reset while waiting on slave 3.
        @(negedge clk);
        bus.mem_addr = 32'h0043_0000; bus.mem_rstrb = 1'b1;
        @(negedge clk);
        bus.mem_rstrb = 1'b0;
        @(negedge clk);
        #1;
        chk("ar_rbusy_before", 32'(bus.mem_rbusy), 32'h1);
        resetn = 1'b0;
        #1;
        chk("ar_rbusy", 32'(bus.mem_rbusy), 32'h0);
        chk("ar_cs", 32'(bus.cs), 32'h0);
        chk("ar_rdata", bus.mem_rdata, 32'h0);
        chk("ar_err_addr", bus.err_addr, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        bus.mem_addr = 32'h0000_2000; bus.mem_rstrb = 1'b1; bus.s_ready = 8'h80;
        #1;
        chk("ar_post_cs", 32'(bus.cs), 32'h80);
        @(negedge clk);
        bus.mem_rstrb = 1'b0; bus.s_ready = 8'h00;
        #1;
        chk("ar_post_rdata", bus.mem_rdata, 32'h1234_5678);
        chk("ar_post_rbusy", 32'(bus.mem_rbusy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_interconnect_ws.md
Name: bus_interconnect_ws

Overview:
Parametrised successor to the fixed 7-way chip-select decoder between FemtoRV32 and its peripherals. It decodes the CPU address into NUM_SLAVES one-hot selects and muxes and registers slave read data. It adds per-slave ready handshakes that drive the CPU's mem_rbusy/mem_wbusy instead of tying them low. A timeout watchdog returns an error word and records a sticky bus error when a slave never answers.

Parameters:
NUM_SLAVES, 8, number of slave ports (2..16); the last index is the default slave (RAM)
BASE_ADDR, 32'h0040_0000, base of the peripheral window
REGION_BITS, 16, log2 of each peripheral region size (64 KiB)
TIMEOUT, 15, maximum wait cycles before abort (1..255)
ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
mem_addr  in  32  CPU address
mem_rstrb  in  1  CPU read strobe, single-cycle pulse
mem_wmask  in  4  CPU byte write mask; any bit set means write request
mem_rdata  out  32  registered read data to CPU
mem_rbusy  out  1  read in progress
mem_wbusy  out  1  write in progress
cs  out  NUM_SLAVES  one-hot slave select
s_rd  out  1  read pulse to slaves, qualified by cs
s_wr  out  1  write pulse to slaves, qualified by cs
s_rdata  in  32*NUM_SLAVES  packed slave read data; slave i occupies bits [32i+31:32i]
s_ready  in  NUM_SLAVES  slave i completes the access in this cycle
err_clr  in  1  clears bus_err
bus_err  out  1  sticky timeout flag
err_addr  out  32  address of the most recent timed-out access

Behaviour:
- Reset (async, resetn=0): state IDLE; mem_rdata=0, mem_rbusy=0, mem_wbusy=0, cs=0, s_rd=0, s_wr=0, bus_err=0, err_addr=0, wait counter=0.
- Decode: if BASE_ADDR <= mem_addr < BASE_ADDR + ((NUM_SLAVES-1) << REGION_BITS), then idx = (mem_addr - BASE_ADDR) >> REGION_BITS. Any other address gives idx = NUM_SLAVES-1.
- Request: req = mem_rstrb | (|mem_wmask). Sampled only in IDLE.
- Read/write priority: if both strobes occur in the same cycle, the write wins and s_rd stays low.
- IDLE, cycle T with req:
  - cs = onehot(idx) combinationally.
  - s_rd or s_wr = 1 for cycle T only.
  - idx, access type and mem_addr are latched.
- Zero-wait completion: if s_ready[idx]=1 in cycle T, state stays IDLE. For a read, mem_rdata <= s_rdata[idx] at the end of T, so data is valid at T+1 with busy low. This matches the existing 1-cycle RAM timing.
- Wait entry: if s_ready[idx]=0 in cycle T, go to WAIT and clear the counter.
- WAIT state:
  - mem_rbusy (read) or mem_wbusy (write) = 1, driven from state, registered only.
  - cs = onehot(latched idx); s_rd and s_wr = 0.
  - The counter increments each cycle.
- WAIT completion: on s_ready[latched idx]=1, a read captures mem_rdata <= s_rdata[idx]; then return to IDLE.
- Ready from non-selected slaves is ignored.
- Timeout: if WAIT lasts TIMEOUT cycles without ready:
  - a read gets mem_rdata <= ERR_DATA;
  - bus_err <= 1 and err_addr <= latched addr;
  - return to IDLE, so busy falls the next cycle.
- Ready arriving in the same cycle as the timeout: ready wins and there is no error.
- Requests in WAIT: ignored; the CPU never issues them.
- Writes never modify mem_rdata.
- err_clr clears bus_err. If err_clr and a new timeout occur in the same cycle, the set wins. err_addr is never cleared except by reset.
- No combinational path from s_ready to mem_rbusy or mem_wbusy.

Test Plan:
1. Zero-wait RAM read: mem_addr=0x0000_1000, rstrb, s_ready[7]=1, s_rdata[7]=0x1234_5678 -> cs=0x80 at T; mem_rdata=0x1234_5678 at T+1; mem_rbusy never 1.
2. Peripheral decode: reads at 0x0040_0004, 0x0042_0000, 0x0046_FFFC -> cs=0x01, 0x04, 0x40. Read at 0x0047_0000 -> cs=0x80 (default).
3. Wait states: read at slave 2, s_ready[2] asserted 3 cycles after T -> mem_rbusy high T+1..T+3; data captured; mem_rbusy low at T+4; s_rd high only at T.
4. Write with waits: mem_wmask=4'b0011 to 0x0040_0000, ready after 2 cycles -> s_wr pulse at T, mem_wbusy high T+1..T+2, mem_rdata unchanged.
5. Timeout: read 0x0041_0010, slave 1 never ready -> after 15 WAIT cycles mem_rdata=0xDEAD_BEEF, bus_err=1, err_addr=0x0041_0010, rbusy low next cycle. err_clr -> bus_err=0. Also check err_clr and a new timeout in the same cycle -> bus_err=1.
6. Async reset mid-WAIT: drop resetn while in WAIT -> all outputs 0 immediately, with no clock edge needed. After release, a new request proceeds normally.
